// File: rtl/rca8_seq_ctrl.sv
// rca8_seq_ctrl - adds two 8*NBYTES-bit operands with one shared 8-bit
// ripple-carry adder. It works on one byte per clock, starting with the least
// significant byte, and passes the carry between bytes in an internal register.
//
// Optional feature: define RCA8_SEQ_SUB_EN to add the `sub` port.
// When sub=1 the block computes A-B: B is inverted and the initial carry is 1.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request pulse, accepted in IDLE or DONE
//   a, b   in   operands (8*NBYTES bits), latched on accept
//   cin    in   carry into byte 0, latched on accept
//   sub    in   (RCA8_SEQ_SUB_EN only) subtract select, latched on accept
//   busy   out  operation in progress
//   done   out  one-cycle result-valid pulse
//   sum    out  result, stable from done until the next accept
//   cout   out  carry out of the MSB byte (for subtract, 1 = no borrow)
//   ovf    out  two's-complement overflow

module rca8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[8];
endmodule

module rca8_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef RCA8_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic          drain;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q;
  logic          sub_in;
  logic          c0;

  logic [7:0]    a_byte, b_eff, s_byte;
  logic          c_byte;
  logic          last;

`ifdef RCA8_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction forces the initial carry to 1 and ignores cin.
  assign c0 = sub_in ? 1'b1 : cin;

  assign a_byte = a_q[{idx, 3'b000} +: 8];
  assign b_eff  = b_q[{idx, 3'b000} +: 8] ^ {8{sub_q}};
  assign last   = (idx == IW'(NBYTES - 1));

  rca8 u_rca8 (
    .x  (a_byte),
    .y  (b_eff),
    .ci (carry),
    .s  (s_byte),
    .co (c_byte)
  );

  // After the last byte is written, RUN stays active for one more cycle
  // (`drain`). That gives the accept-to-done latency of NBYTES+1 edges and
  // leaves the full result on the bus for a cycle before done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      drain <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub_in;
            carry <= c0;
            idx   <= '0;
            drain <= 1'b0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (drain) begin
            drain <= 1'b0;
            state <= S_DONE;
          end else begin
            sum[{idx, 3'b000} +: 8] <= s_byte;
            carry <= c_byte;
            if (last) begin
              cout  <= c_byte;
              ovf   <= (a_byte[7] == b_eff[7]) && (s_byte[7] != a_byte[7]);
              drain <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
endmodule
